mem_wb_data_stage: RTL and testbench
====================================

Name: mem_wb_data_stage

Overview:
Parametrised MEM/WB write-back data stage for the pipelined RV CPU. It replaces the fixed-latency, cache-embedded write-back block with a valid/ready memory port, so the data memory or cache may take any number of cycles. The block holds a miss/stall FSM, aligns store byte lanes, sign/zero-extends loads, and keeps bubble/flush semantics on the registered write-back value.

Parameters:
XLEN, 32, datapath width; legal values are 32 and 64.
ADDR_W, 32, byte address width.
STRB_W, XLEN/8, byte-strobe width (derived; do not override).

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
bubbleW  in  1  hold the WB output register
flushW  in  1  zero the WB output and kill the in-flight access
wb_select  in  1  1 = write back load data, 0 = write back addr (ALU result)
load_type  in  3  0 none, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU, 6 LWU, 7 LD (6 and 7 only when XLEN=64)
write_en  in  STRB_W  store byte mask, unshifted (LSB-justified)
addr  in  ADDR_W  effective address / ALU result
in_data  in  XLEN  store data, unshifted
mem_req  out  1  request valid
mem_we  out  1  1 = store
mem_addr  out  ADDR_W  address aligned to XLEN/8 bytes
mem_wstrb  out  STRB_W  shifted byte strobe
mem_wdata  out  XLEN  shifted store data
mem_ready  in  1  request accepted
mem_rvalid  in  1  load data valid
mem_rdata  in  XLEN  raw load word
miss  out  1  stall request to the hazard unit
misalign  out  1  one-cycle pulse: misaligned access rejected
data_WB  out  XLEN  registered write-back value
wb_valid  out  1  data_WB holds a live, unflushed result

Behaviour:
- Access: load_type!=0 or write_en!=0. When both are set, the store wins and the load is ignored.
- off = addr[log2(STRB_W)-1:0].
- Misaligned cases:
  - LH/LHU with off[0]=1.
  - LW/LWU with off[1:0]!=0.
  - LD with off!=0.
  - Store whose (write_en<<off) overflows STRB_W.
  - A misaligned access issues no request, pulses misalign for that cycle, and captures 0 into data_WB with wb_valid=0.
- FSM states: IDLE, REQ, WAIT, DONE. The request is captured into internal registers on the IDLE->REQ edge.
  - IDLE: aligned access and !flushW -> REQ. Otherwise stay in IDLE.
  - REQ: mem_req=1, outputs are stable from the captured registers. mem_ready=1 -> DONE if store, WAIT if load.
  - WAIT: mem_rvalid=1 -> latch mem_rdata -> DONE. mem_rvalid arriving in the same cycle as mem_ready is not legal.
  - DONE: always -> IDLE.
- miss = (IDLE && aligned access && !flushW) || REQ || WAIT. miss is 0 in DONE.
- The pipeline holds its inputs while miss=1.
- Minimum stall: a store takes 2 cycles (IDLE, REQ); a load takes 3 cycles (IDLE, REQ, WAIT).
- data_WB update: occurs at a posedge where miss=0. Priority order:
  1. rst -> 0
  2. bubbleW -> hold
  3. flushW or kill -> 0
  4. wb_select ? ext(rdata_latched or n/a) : addr
- wb_valid follows data_WB: 1 on a capture, 0 on reset/flush/kill/misalign, held on bubble.
- Extension: select the byte, half or word at off. LB/LH/LW sign-extend to XLEN; LBU/LHU/LWU zero-extend.
- Kill: flushW=1 in REQ or WAIT sets a sticky kill flag.
  - The handshake still completes; the transaction is never abandoned.
  - The result is discarded at DONE, giving data_WB=0.
  - kill clears on DONE.
- Stores with wb_select=0 write back addr as usual.
- Reset in any state: next state IDLE, mem_req=0, kill=0, data_WB=0, wb_valid=0, misalign=0. The memory side shares rst.
- Counters and strobes wrap at STRB_W; no other arithmetic is performed.

Test Plan:
- XLEN=32, LB addr=0x103, rdata=0x80FF_1234, mem_ready at cycle 1, rvalid at cycle 3 -> miss high for 4 cycles; data_WB=0xFFFF_FF80, wb_valid=1.
- SB write_en=0001, addr=0x2, in_data=0xAB, mem_ready immediate -> mem_wstrb=0100, mem_wdata=0x00AB_0000, mem_addr=0x0; miss high 2 cycles; data_WB=0x2.
- LW at addr=0x6 -> no mem_req, misalign pulses 1 cycle, miss=0, data_WB=0, wb_valid=0.
- LHU at 0x40 with flushW raised in WAIT, rvalid after 5 cycles -> request completes, data_WB=0, wb_valid=0; next ALU op with addr=0x55 captures 0x55.
- bubbleW=1 during a non-memory op after a load result of 0x1234 -> data_WB stays 0x1234; rst asserted in WAIT -> mem_req=0 and data_WB=0 at the next edge.
- XLEN=64, LD at 0x8 with rdata=0x8000_0000_0000_0001 -> mem_addr=0x8, data_WB=0x8000_0000_0000_0001; LWU at 0xC with the same rdata -> 0x0000_0000_8000_0000.

Source files
------------

// File: rtl/mem_wb_data_stage_if.sv
// Memory-side port of the MEM/WB data stage: one request channel, one load-return channel.
interface mem_wb_data_stage_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
);
  localparam int STRB_W = XLEN / 8;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [STRB_W-1:0] mem_wstrb;
  logic [XLEN-1:0]   mem_wdata;
  logic              mem_ready;
  logic              mem_rvalid;
  logic [XLEN-1:0]   mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
    input  mem_ready, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
    output mem_ready, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/mem_wb_data_stage.sv
// MEM/WB write-back stage with a variable-latency valid/ready memory port.
// States: IDLE waits for an access | REQ holds the request | WAIT awaits load data | DONE retires it
module mem_wb_data_stage #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32,
  parameter int STRB_W = XLEN / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bubbleW_i,
  input  logic              flushW_i,
  input  logic              wb_select_i,
  input  logic [2:0]        load_type_i,
  input  logic [STRB_W-1:0] write_en_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [XLEN-1:0]   in_data_i,
  mem_wb_data_stage_if.master mem,
  output logic              miss_o,
  output logic              misalign_o,
  output logic [XLEN-1:0]   data_WB_o,
  output logic              wb_valid_o
);

  localparam int OFF_W = $clog2(STRB_W);

  localparam logic [2:0] LT_NONE = 3'd0;
  localparam logic [2:0] LT_LB   = 3'd1;
  localparam logic [2:0] LT_LH   = 3'd2;
  localparam logic [2:0] LT_LW   = 3'd3;
  localparam logic [2:0] LT_LBU  = 3'd4;
  localparam logic [2:0] LT_LHU  = 3'd5;
  localparam logic [2:0] LT_LWU  = 3'd6;
  localparam logic [2:0] LT_LD   = 3'd7;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t              state_q, state_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic [XLEN-1:0]     wdata_q, wdata_d;
  logic [2:0]          lt_q, lt_d;
  logic [OFF_W-1:0]    off_q, off_d;
  logic [XLEN-1:0]     rdata_q, rdata_d;
  logic                kill_q, kill_d;
  logic [XLEN-1:0]     data_q, data_d;
  logic                valid_q, valid_d;

  logic [OFF_W-1:0]    off;
  logic                is_store, is_access, mis_ld, misaligned, start;
  logic [2*STRB_W-1:0] strb_wide;
  logic [XLEN-1:0]     lane, ext, addr_x;

  assign off       = addr_i[OFF_W-1:0];
  assign is_store  = |write_en_i;
  assign is_access = is_store || (load_type_i != LT_NONE);
  assign strb_wide = {{STRB_W{1'b0}}, write_en_i} << off;

  always_comb begin
    mis_ld = 1'b0;
    case (load_type_i)
      LT_LH, LT_LHU: mis_ld = off[0];
      LT_LW, LT_LWU: mis_ld = |off[1:0];
      LT_LD:         mis_ld = |off;
      default:       mis_ld = 1'b0;
    endcase
  end

  // A store wins over a simultaneous load, so only its lane overflow matters.
  assign misaligned = is_store ? |strb_wide[2*STRB_W-1:STRB_W] : mis_ld;
  assign start      = (state_q == S_IDLE) && is_access && !misaligned && !flushW_i;

  assign miss_o     = start || (state_q == S_REQ) || (state_q == S_WAIT);
  assign misalign_o = !rst && (state_q == S_IDLE) && is_access && misaligned && !flushW_i;

  generate
    if (ADDR_W >= XLEN) begin : g_addr_trunc
      assign addr_x = addr_i[XLEN-1:0];
    end else begin : g_addr_zext
      assign addr_x = {{(XLEN-ADDR_W){1'b0}}, addr_i};
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wstrb_d = wstrb_q;
    wdata_d = wdata_q;
    lt_d    = lt_q;
    off_d   = off_q;
    rdata_d = rdata_q;
    kill_d  = kill_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_REQ;
          we_d    = is_store;
          addr_d  = {addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
          wstrb_d = is_store ? strb_wide[STRB_W-1:0] : '0;
          wdata_d = in_data_i << {off, 3'b000};
          lt_d    = is_store ? LT_NONE : load_type_i;
          off_d   = off;
        end
      end
      S_REQ: begin
        if (flushW_i) kill_d = 1'b1;
        if (mem.mem_ready) state_d = we_q ? S_DONE : S_WAIT;
      end
      S_WAIT: begin
        if (flushW_i) kill_d = 1'b1;
        if (mem.mem_rvalid) begin
          rdata_d = mem.mem_rdata;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        kill_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    lane = rdata_q >> {off_q, 3'b000};
    case (lt_q)
      LT_LB:   ext = XLEN'($signed(lane[7:0]));
      LT_LH:   ext = XLEN'($signed(lane[15:0]));
      LT_LW:   ext = XLEN'($signed(lane[31:0]));
      LT_LBU:  ext = XLEN'(lane[7:0]);
      LT_LHU:  ext = XLEN'(lane[15:0]);
      LT_LWU:  ext = XLEN'(lane[31:0]);
      LT_LD:   ext = lane;
      default: ext = '0;
    endcase
  end

  // A killed transaction still retires through DONE, but its result is dropped.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (!miss_o && !bubbleW_i) begin
      if (flushW_i || misalign_o || ((state_q == S_DONE) && kill_q)) begin
        data_d  = '0;
        valid_d = 1'b0;
      end else begin
        data_d  = wb_select_i ? ext : addr_x;
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wstrb_q <= '0;
      wdata_q <= '0;
      lt_q    <= LT_NONE;
      off_q   <= '0;
      rdata_q <= '0;
      kill_q  <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wstrb_q <= wstrb_d;
      wdata_q <= wdata_d;
      lt_q    <= lt_d;
      off_q   <= off_d;
      rdata_q <= rdata_d;
      kill_q  <= kill_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign mem.mem_req   = (state_q == S_REQ);
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wstrb = wstrb_q;
  assign mem.mem_wdata = wdata_q;

  assign data_WB_o  = data_q;
  assign wb_valid_o = valid_q;

endmodule

// File: tb/tb_mem_wb_data_stage.sv
// Directed bench for mem_wb_data_stage: a 32-bit and a 64-bit instance, one active at a time.
module tb_mem_wb_data_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        bubbleW, flushW, wb_select;
  logic [2:0]  load_type;
  logic [7:0]  write_en;
  logic [31:0] addr;
  logic [63:0] in_data;
  logic        mem_ready, mem_rvalid;
  logic [63:0] mem_rdata;
  bit          sel64;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_wb_data_stage_if #(.XLEN(32), .ADDR_W(32)) m32 ();
  mem_wb_data_stage_if #(.XLEN(64), .ADDR_W(32)) m64 ();

  logic        miss32, mis32, val32;
  logic [31:0] data32;
  logic        miss64, mis64, val64;
  logic [63:0] data64;

  assign m32.mem_ready  = mem_ready && !sel64;
  assign m32.mem_rvalid = mem_rvalid && !sel64;
  assign m32.mem_rdata  = mem_rdata[31:0];
  assign m64.mem_ready  = mem_ready && sel64;
  assign m64.mem_rvalid = mem_rvalid && sel64;
  assign m64.mem_rdata  = mem_rdata;

  mem_wb_data_stage #(.XLEN(32), .ADDR_W(32)) dut32 (
    .clk(clk), .rst(rst), .bubbleW_i(bubbleW), .flushW_i(flushW), .wb_select_i(wb_select),
    .load_type_i(sel64 ? 3'd0 : load_type), .write_en_i(sel64 ? 4'h0 : write_en[3:0]),
    .addr_i(addr), .in_data_i(in_data[31:0]), .mem(m32),
    .miss_o(miss32), .misalign_o(mis32), .data_WB_o(data32), .wb_valid_o(val32)
  );

  mem_wb_data_stage #(.XLEN(64), .ADDR_W(32)) dut64 (
    .clk(clk), .rst(rst), .bubbleW_i(bubbleW), .flushW_i(flushW), .wb_select_i(wb_select),
    .load_type_i(sel64 ? load_type : 3'd0), .write_en_i(sel64 ? write_en : 8'h00),
    .addr_i(addr), .in_data_i(in_data), .mem(m64),
    .miss_o(miss64), .misalign_o(mis64), .data_WB_o(data64), .wb_valid_o(val64)
  );

  wire        miss_s  = sel64 ? miss64 : miss32;
  wire        mis_s   = sel64 ? mis64 : mis32;
  wire        valid_s = sel64 ? val64 : val32;
  wire [63:0] data_s  = sel64 ? data64 : {32'h0, data32};
  wire        req_s   = sel64 ? m64.mem_req : m32.mem_req;
  wire [31:0] addr_s  = sel64 ? m64.mem_addr : m32.mem_addr;
  wire [7:0]  wstrb_s = sel64 ? m64.mem_wstrb : {4'h0, m32.mem_wstrb};
  wire [63:0] wdata_s = sel64 ? m64.mem_wdata : {32'h0, m32.mem_wdata};

  // Plays the memory for one access already presented on the inputs; returns after the retiring edge.
  task automatic run_access(input int ready_at, input int rvalid_at, input logic [63:0] rdata,
                            input int flush_at, output int nmiss, output int nreq,
                            output logic [31:0] a, output logic [7:0] s, output logic [63:0] d);
    logic m;
    nmiss = 0; nreq = 0; a = '0; s = '0; d = '0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      mem_ready  = req_s && (cyc >= ready_at);
      mem_rvalid = (cyc == rvalid_at);
      mem_rdata  = rdata;
      flushW     = (cyc == flush_at);
      #1;
      if (req_s) begin nreq++; a = addr_s; s = wstrb_s; d = wdata_s; end
      m = miss_s;
      if (m) nmiss++;
      @(posedge clk); #1;
      if (!m) break;
    end
    mem_ready = 1'b0; mem_rvalid = 1'b0; flushW = 1'b0;
    load_type = 3'd0; write_en = 8'h00; wb_select = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; bubbleW = 0; flushW = 0; wb_select = 0; load_type = 0; write_en = 0;
    addr = 0; in_data = 0; mem_ready = 0; mem_rvalid = 0; mem_rdata = 0; sel64 = 0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (data_s !== 64'h0) begin n_bad++; $display("FAIL reset_data got %h want 0", data_s); end
    n_cmp++; if (valid_s !== 1'b0 || req_s !== 1'b0 || mis_s !== 1'b0) begin n_bad++;
      $display("FAIL reset_ctrl got valid=%b req=%b mis=%b want 0 0 0", valid_s, req_s, mis_s); end
    rst = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (miss_s !== 1'b0) begin n_bad++; $display("FAIL reset_miss got %b want 0", miss_s); end
  endtask

  task automatic test_load_byte();
    int nm, nr; logic [31:0] a; logic [7:0] s; logic [63:0] d;
    load_type = 3'd1; addr = 32'h103; wb_select = 1;
    run_access(1, 3, 64'h80FF_1234, -1, nm, nr, a, s, d);
    n_cmp++; if (nm !== 4) begin n_bad++; $display("FAIL lb_miss_cycles got %0d want 4", nm); end
    n_cmp++; if (nr !== 1 || a !== 32'h100) begin n_bad++;
      $display("FAIL lb_req got n=%0d addr=%h want 1 00000100", nr, a); end
    n_cmp++; if (data_s !== 64'hFFFF_FF80 || valid_s !== 1'b1) begin n_bad++;
      $display("FAIL lb_data got %h/%b want ffffff80/1", data_s, valid_s); end
  endtask

  task automatic test_load_ext();
    int nm, nr; logic [31:0] a; logic [7:0] s; logic [63:0] d;
    load_type = 3'd2; addr = 32'h102; wb_select = 1;
    run_access(0, 2, 64'h80FF_1234, -1, nm, nr, a, s, d);
    n_cmp++; if (data_s !== 64'hFFFF_80FF) begin n_bad++; $display("FAIL lh_data got %h want ffff80ff", data_s); end
    load_type = 3'd4; addr = 32'h101; wb_select = 1;
    run_access(0, 2, 64'h80FF_1234, -1, nm, nr, a, s, d);
    n_cmp++; if (data_s !== 64'h12) begin n_bad++; $display("FAIL lbu_data got %h want 12", data_s); end
  endtask

  task automatic test_store();
    int nm, nr; logic [31:0] a; logic [7:0] s; logic [63:0] d;
    write_en = 8'h1; addr = 32'h2; in_data = 64'hAB; wb_select = 0;
    run_access(0, -1, 64'h0, -1, nm, nr, a, s, d);
    n_cmp++; if (s !== 8'h4 || d !== 64'h00AB_0000 || a !== 32'h0) begin n_bad++;
      $display("FAIL sb_bus got strb=%h data=%h addr=%h want 4 00ab0000 0", s, d, a); end
    n_cmp++; if (nm !== 2) begin n_bad++; $display("FAIL sb_miss_cycles got %0d want 2", nm); end
    n_cmp++; if (data_s !== 64'h2 || valid_s !== 1'b1) begin n_bad++;
      $display("FAIL sb_wb got %h/%b want 2/1", data_s, valid_s); end
    write_en = 8'h3; addr = 32'h1A; in_data = 64'hBEEF; wb_select = 0;
    run_access(0, -1, 64'h0, -1, nm, nr, a, s, d);
    n_cmp++; if (s !== 8'hC || d !== 64'hBEEF_0000 || a !== 32'h18) begin n_bad++;
      $display("FAIL sh_bus got strb=%h data=%h addr=%h want c beef0000 18", s, d, a); end
  endtask

  task automatic test_misalign();
    load_type = 3'd3; addr = 32'h6; wb_select = 1;
    #1;
    n_cmp++; if (mis_s !== 1'b1 || miss_s !== 1'b0 || req_s !== 1'b0) begin n_bad++;
      $display("FAIL lw_misalign got mis=%b miss=%b req=%b want 1 0 0", mis_s, miss_s, req_s); end
    @(posedge clk); #1;
    load_type = 3'd0; wb_select = 0;
    n_cmp++; if (data_s !== 64'h0 || valid_s !== 1'b0) begin n_bad++;
      $display("FAIL lw_misalign_wb got %h/%b want 0/0", data_s, valid_s); end
    #1;
    n_cmp++; if (mis_s !== 1'b0 || req_s !== 1'b0) begin n_bad++;
      $display("FAIL misalign_pulse got mis=%b req=%b want 0 0", mis_s, req_s); end
    write_en = 8'h3; addr = 32'h3;
    #1;
    n_cmp++; if (mis_s !== 1'b1 || miss_s !== 1'b0) begin n_bad++;
      $display("FAIL sh_overflow got mis=%b miss=%b want 1 0", mis_s, miss_s); end
    @(posedge clk); #1;
    write_en = 8'h0;
  endtask

  task automatic test_flush_kill();
    int nm, nr; logic [31:0] a; logic [7:0] s; logic [63:0] d;
    load_type = 3'd5; addr = 32'h40; wb_select = 1;
    run_access(1, 5, 64'h0000_BEEF, 2, nm, nr, a, s, d);
    n_cmp++; if (nm !== 6 || nr !== 1) begin n_bad++;
      $display("FAIL kill_handshake got miss=%0d req=%0d want 6 1", nm, nr); end
    n_cmp++; if (data_s !== 64'h0 || valid_s !== 1'b0) begin n_bad++;
      $display("FAIL kill_wb got %h/%b want 0/0", data_s, valid_s); end
    addr = 32'h55; wb_select = 0;
    @(posedge clk); #1;
    n_cmp++; if (data_s !== 64'h55 || valid_s !== 1'b1) begin n_bad++;
      $display("FAIL after_kill_alu got %h/%b want 55/1", data_s, valid_s); end
  endtask

  task automatic test_bubble();
    int nm, nr; logic [31:0] a; logic [7:0] s; logic [63:0] d;
    load_type = 3'd3; addr = 32'h200; wb_select = 1;
    run_access(0, 2, 64'h1234, -1, nm, nr, a, s, d);
    n_cmp++; if (nm !== 3 || data_s !== 64'h1234 || valid_s !== 1'b1) begin n_bad++;
      $display("FAIL lw_data got miss=%0d data=%h/%b want 3 1234/1", nm, data_s, valid_s); end
    addr = 32'h77; wb_select = 0; bubbleW = 1;
    @(posedge clk); #1;
    n_cmp++; if (data_s !== 64'h1234 || valid_s !== 1'b1) begin n_bad++;
      $display("FAIL bubble_hold got %h/%b want 1234/1", data_s, valid_s); end
    bubbleW = 0;
    @(posedge clk); #1;
    n_cmp++; if (data_s !== 64'h77) begin n_bad++; $display("FAIL bubble_release got %h want 77", data_s); end
  endtask

  task automatic test_reset_in_wait();
    load_type = 3'd3; addr = 32'h300; wb_select = 1;
    @(posedge clk); #1;
    mem_ready = 1;
    #1;
    n_cmp++; if (req_s !== 1'b1) begin n_bad++; $display("FAIL rstw_req got %b want 1", req_s); end
    @(posedge clk); #1;
    mem_ready = 0;
    n_cmp++; if (miss_s !== 1'b1 || req_s !== 1'b0) begin n_bad++;
      $display("FAIL rstw_wait got miss=%b req=%b want 1 0", miss_s, req_s); end
    rst = 1; load_type = 0; wb_select = 0;
    @(posedge clk); #1;
    n_cmp++; if (req_s !== 1'b0 || data_s !== 64'h0 || valid_s !== 1'b0 || miss_s !== 1'b0) begin n_bad++;
      $display("FAIL rstw_after got req=%b data=%h valid=%b miss=%b want 0 0 0 0", req_s, data_s, valid_s, miss_s); end
    rst = 0;
    addr = 32'h9;
    @(posedge clk); #1;
    n_cmp++; if (data_s !== 64'h9 || valid_s !== 1'b1) begin n_bad++;
      $display("FAIL rstw_recover got %h/%b want 9/1", data_s, valid_s); end
  endtask

  task automatic test_xlen64();
    int nm, nr; logic [31:0] a; logic [7:0] s; logic [63:0] d;
    sel64 = 1;
    load_type = 3'd7; addr = 32'h8; wb_select = 1;
    run_access(0, 2, 64'h8000_0000_0000_0001, -1, nm, nr, a, s, d);
    n_cmp++; if (a !== 32'h8 || data_s !== 64'h8000_0000_0000_0001) begin n_bad++;
      $display("FAIL ld64 got addr=%h data=%h want 8 8000000000000001", a, data_s); end
    load_type = 3'd6; addr = 32'hC; wb_select = 1;
    run_access(0, 2, 64'h8000_0000_0000_0001, -1, nm, nr, a, s, d);
    n_cmp++; if (a !== 32'h8 || data_s !== 64'h0000_0000_8000_0000) begin n_bad++;
      $display("FAIL lwu64 got addr=%h data=%h want 8 0000000080000000", a, data_s); end
    load_type = 3'd3; addr = 32'hC; wb_select = 1;
    run_access(0, 2, 64'h8000_0000_0000_0001, -1, nm, nr, a, s, d);
    n_cmp++; if (data_s !== 64'hFFFF_FFFF_8000_0000) begin n_bad++;
      $display("FAIL lw64 got %h want ffffffff80000000", data_s); end
    load_type = 3'd7; addr = 32'h4;
    #1;
    n_cmp++; if (mis_s !== 1'b1 || miss_s !== 1'b0) begin n_bad++;
      $display("FAIL ld64_misalign got mis=%b miss=%b want 1 0", mis_s, miss_s); end
    @(posedge clk); #1;
    load_type = 3'd0;
    sel64 = 0;
  endtask

  initial begin
    test_reset();
    test_load_byte();
    test_load_ext();
    test_store();
    test_misalign();
    test_flush_kill();
    test_bubble();
    test_reset_in_wait();
    test_xlen64();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "timeout");
  end

endmodule
